rv32i_instr_encoder: RTL and testbench
======================================

// Module: rv32i_instr_encoder
// PURPOSE
//  Encodes decoded RV32I instruction fields (class, regs, funct3, alt bit, 32-bit immediate) into 32-bit machine words.
//  It is the inverse of the RV32I decoder: the output is bit-exact with what the decoder expects.
//  Feeds the instruction-memory loader / self-test generator through a valid/ready FIFO.
//  Each emitted word is tagged with a sequential word address.
// PARAMETERS
//  DEPTH      2    output FIFO entries (>=2)
//  ADDRW      10   width of the word-address counter
//  BASE_ADDR  0    out_addr value after reset
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous reset, active-high
//  req_valid   in   1      request fields valid
//  req_ready   out  1      encoder can accept this cycle
//  req_class   in   4      0 OPPI,1 OPPR,2 LUI,3 AUIPC,4 JAL,5 JALR,6 BRANCH,7 LOAD,8 STORE
//  req_rd      in   5      destination reg -> [11:7]
//  req_rs1     in   5      source reg 1 -> [19:15]
//  req_rs2     in   5      source reg 2 -> [24:20]
//  req_funct3  in   3      funct3 / branch type / load-store width -> [14:12]
//  req_alt     in   1      funct7[5] (SUB/SRA/SRAI select)
//  req_imm     in   32     full-value immediate (byte offset for B/J, full value for U)
//  out_valid   out  1      FIFO head valid
//  out_ready   in   1      consumer accepts head
//  out_ins     out  32     encoded instruction
//  out_addr    out  ADDRW  word address of head
//  out_err     out  1      head flagged illegal / out-of-range
// BEHAVIOUR
//  - Handshakes: push on req_valid&&req_ready; pop on out_valid&&out_ready.
//  - Latency: a word pushed at edge N is visible on out_* after edge N (cycle N+1) if the FIFO was empty.
//  - req_ready = !full, registered. No push when full, even if a pop occurs in the same cycle.
//  - Simultaneous push and pop when not full: count unchanged, order preserved.
//  - Opcodes: OPPI 0010011, OPPR 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111,
//    JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011.
//  - Immediate formats:
//    - I: imm[11:0] -> [31:20].
//    - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
//    - B: imm[12|10:5] -> [31|30:25], imm[4:1|11] -> [11:8|7].
//    - U: imm[31:12] -> [31:12].
//    - J: imm[20|10:1|11|19:12] -> [31|30:21|20|19:12].
//  - OPPR: funct7 = {1'b0, req_alt, 5'b0}.
//  - OPPI with funct3 001/101: [31:25] = {1'b0, req_alt, 5'b0}, [24:20] = imm[4:0]. Other funct3: req_alt ignored.
//  - Unused fields are zero: LUI/AUIPC/JAL funct3, rs1, rs2; I-type rs2; S/B rd. JALR funct3 forced 000.
//  - req_class > 8: word = 32'h0000_0013 (NOP) and err = 1. This applies regardless of macro.
//  - out_addr counter: starts at BASE_ADDR and increments by 1 per push, stored with the entry.
//    Wraps modulo 2^ADDRW with no flag.
//  - Reset (any cycle, including mid-burst): FIFO flushed, out_valid=0, out_ins=0, out_err=0,
//    out_addr=BASE_ADDR, req_ready=1 in the cycle after the reset edge. Requests presented during reset are dropped.
//  - out_ins/out_addr/out_err hold their values while out_valid && !out_ready.
// CONFIGURATION
//  - ENC_RANGE_CHECK_EN defined: err = 1 when any of the following holds (the word is still emitted, with truncated fields):
//    - I/S imm not a sign-extended 12-bit value;
//    - B imm not 13-bit signed or imm[0] != 0;
//    - J imm not 21-bit signed or imm[0] != 0;
//    - U imm[11:0] != 0;
//    - OPPI shift with imm[31:5] != 0.
//  - ENC_RANGE_CHECK_EN undefined: no range logic; fields are silently truncated; err comes only from illegal class.
// TESTING
//  - OPPI rd=1 rs1=2 f3=0 imm=5 -> out_ins 0x00510093, err 0, out_addr 0.
//  - OPPR rd=3 rs1=1 rs2=2 f3=0 alt=1 -> 0x402081B3 (sub), out_addr 1.
//  - BRANCH rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3. JAL rd=1 imm=8 -> 0x008000EF.
//  - STORE rs1=2 rs2=5 f3=2 imm=12 -> 0x00512623. OPPI imm=2048 -> err 1 with macro, err 0 without.
//  - DEPTH=2, out_ready=0, 3 back-to-back requests -> req_ready low after 2nd, 3rd held.
//    Then release out_ready -> words drained in order.
//  - Reset asserted with 2 entries queued -> out_valid 0, out_addr BASE_ADDR next cycle.
//    With ADDRW=2, 5 pushes -> addr sequence 0,1,2,3,0.

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
//   Packs decoded RV32I fields into 32-bit machine words. The output is bit-exact
//   with what the RV32I decoder expects. Each word is tagged with a sequential word
//   address and queued in a small valid/ready output FIFO.
//   Optional macro: ENC_RANGE_CHECK_EN flags immediates that do not fit their format.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     req_valid/req_ready      request handshake (req_ready is registered !full)
//     req_class                0 OPPI,1 OPPR,2 LUI,3 AUIPC,4 JAL,5 JALR,6 BRANCH,7 LOAD,8 STORE
//     req_rd/rs1/rs2/funct3    register and funct3 fields
//     req_alt                  funct7[5] select (SUB/SRA/SRAI)
//     req_imm                  full-value immediate
//     out_valid/out_ready      FIFO head handshake
//     out_ins/out_addr/out_err head word, its word address, illegal/range flag
module rv32i_instr_encoder #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ADDRW     = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_class,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [2:0]       req_funct3,
    input  logic             req_alt,
    input  logic [31:0]      req_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_ins,
    output logic [ADDRW-1:0] out_addr,
    output logic             out_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef struct packed {
        logic [31:0]      ins;
        logic [ADDRW-1:0] addr;
        logic             err;
    } entryT;

    logic [31:0] encIns;
    logic        classErr;
    logic        rangeErr;
    logic        encErr;
    logic        isShift;

    assign isShift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);

    // Field packing per instruction class; unknown classes become a flagged NOP.
    always_comb begin
        encIns   = 32'h0000_0013;
        classErr = 1'b0;
        case (req_class)
            4'd0: begin
                if (isShift) begin
                    encIns = {1'b0, req_alt, 5'b0, req_imm[4:0], req_rs1, req_funct3, req_rd, OP_IMM};
                end else begin
                    encIns = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_IMM};
                end
            end
            4'd1: encIns = {1'b0, req_alt, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OP_REG};
            4'd2: encIns = {req_imm[31:12], req_rd, OP_LUI};
            4'd3: encIns = {req_imm[31:12], req_rd, OP_AUIPC};
            4'd4: encIns = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
            4'd5: encIns = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
            4'd6: encIns = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                            req_imm[4:1], req_imm[11], OP_BRANCH};
            4'd7: encIns = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
            4'd8: encIns = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OP_STORE};
            default: classErr = 1'b1;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic fitsI;
    logic fitsB;
    logic fitsJ;

    // Immediate fits its format when the bits above the field are a pure sign extension.
    always_comb begin
        fitsI    = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);
        fitsB    = ((req_imm[31:12] == '0) || (req_imm[31:12] == '1)) && !req_imm[0];
        fitsJ    = ((req_imm[31:20] == '0) || (req_imm[31:20] == '1)) && !req_imm[0];
        rangeErr = 1'b0;
        case (req_class)
            4'd0:              rangeErr = isShift ? (req_imm[31:5] != '0) : !fitsI;
            4'd2, 4'd3:        rangeErr = (req_imm[11:0] != '0);
            4'd4:              rangeErr = !fitsJ;
            4'd5, 4'd7, 4'd8:  rangeErr = !fitsI;
            4'd6:              rangeErr = !fitsB;
            default:           rangeErr = 1'b0;
        endcase
    end
`else
    assign rangeErr = 1'b0;
`endif

    assign encErr = classErr | rangeErr;

    // Shift-register FIFO: entry 0 is the head and drives the outputs directly.
    entryT          ent  [DEPTH];
    entryT          entN [DEPTH];
    logic [CW-1:0]  count;
    logic [CW-1:0]  countN;
    logic [CW-1:0]  wrIdx;
    logic [ADDRW-1:0] addrCnt;
    logic           push;
    logic           pop;

    assign push   = req_valid && req_ready;
    assign pop    = out_valid && out_ready;
    assign wrIdx  = count - CW'(pop);
    assign countN = count + CW'(push) - CW'(pop);

    always_comb begin
        entN = ent;
        if (pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                entN[i] = ent[i + 1];
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push && (wrIdx == CW'(i))) begin
                entN[i] = '{ins: encIns, addr: addrCnt, err: encErr};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent[i] <= '{ins: 32'h0, addr: ADDRW'(BASE_ADDR), err: 1'b0};
            end
            count     <= '0;
            addrCnt   <= ADDRW'(BASE_ADDR);
            out_valid <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            ent       <= entN;
            count     <= countN;
            out_valid <= (countN != '0);
            req_ready <= (countN < CW'(DEPTH));
            if (push) begin
                addrCnt <= addrCnt + ADDRW'(1);
            end
        end
    end

    assign out_ins  = ent[0].ins;
    assign out_addr = ent[0].addr;
    assign out_err  = ent[0].err;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed encodings, FIFO backpressure,
// reset flush, and randomized traffic against an arithmetic encoder/queue model.
module tb_rv32i_instr_encoder;

    localparam int unsigned DEPTH     = 2;
    localparam int unsigned ADDRW     = 10;
    localparam int unsigned BASE_ADDR = 0;
`ifdef ENC_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_class;
    logic [4:0]       req_rd;
    logic [4:0]       req_rs1;
    logic [4:0]       req_rs2;
    logic [2:0]       req_funct3;
    logic             req_alt;
    logic [31:0]      req_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_ins;
    logic [ADDRW-1:0] out_addr;
    logic             out_err;

    always #5 clk = ~clk;

    rv32i_instr_encoder #(.DEPTH(DEPTH), .ADDRW(ADDRW), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_alt(req_alt), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ins(out_ins), .out_addr(out_addr), .out_err(out_err)
    );

    typedef struct {
        logic [31:0]      ins;
        logic [ADDRW-1:0] addr;
        logic             err;
    } expT;

    expT              expQ [$];
    logic [ADDRW-1:0] mAddr;
    int               nChecks = 0;
    int               nFail   = 0;

    // Reference encoder built from the format rules with shifts and masks.
    function automatic expT modelEnc(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                                     input logic [31:0] imm);
        logic [31:0] w;
        logic [31:0] r, s1, s2, f, a;
        int          sv;
        logic        bad;
        expT         e;
        r   = 32'(rd) << 7;
        s1  = 32'(rs1) << 15;
        s2  = 32'(rs2) << 20;
        f   = 32'(f3) << 12;
        a   = 32'(alt) << 30;
        sv  = $signed(imm);
        bad = 1'b0;
        w   = 32'h13;
        case (cls)
            4'd0: if (f3 == 3'd1 || f3 == 3'd5) begin
                      w = a | ((imm & 32'd31) << 20) | s1 | f | r | 32'h13;
                      bad = imm > 32'd31;
                  end else begin
                      w = ((imm & 32'hFFF) << 20) | s1 | f | r | 32'h13;
                      bad = !(sv >= -2048 && sv <= 2047);
                  end
            4'd1: w = a | s2 | s1 | f | r | 32'h33;
            4'd2: begin w = (imm & 32'hFFFF_F000) | r | 32'h37; bad = (imm & 32'hFFF) != 0; end
            4'd3: begin w = (imm & 32'hFFFF_F000) | r | 32'h17; bad = (imm & 32'hFFF) != 0; end
            4'd4: begin
                w = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) |
                    (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | r | 32'h6F;
                bad = !(sv >= -1048576 && sv <= 1048575) || imm[0];
            end
            4'd5: begin w = ((imm & 32'hFFF) << 20) | s1 | r | 32'h67; bad = !(sv >= -2048 && sv <= 2047); end
            4'd6: begin
                w = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | s2 | s1 | f |
                    (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | 32'h63;
                bad = !(sv >= -4096 && sv <= 4095) || imm[0];
            end
            4'd7: begin w = ((imm & 32'hFFF) << 20) | s1 | f | r | 32'h03; bad = !(sv >= -2048 && sv <= 2047); end
            4'd8: begin
                w = (((imm >> 5) & 32'd127) << 25) | s2 | s1 | f | ((imm & 32'd31) << 7) | 32'h23;
                bad = !(sv >= -2048 && sv <= 2047);
            end
            default: w = 32'h13;
        endcase
        e.ins  = w;
        e.addr = '0;
        e.err  = (cls > 4'd8) ? 1'b1 : (RANGE_CHECK && bad);
        return e;
    endfunction

    task automatic setReq(input logic [3:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                          input logic [31:0] imm, input logic v);
        req_class = cls; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_alt = alt; req_imm = imm; req_valid = v;
    endtask

    task automatic randReq();
        logic [31:0] imm;
        imm = $urandom;
        case ($urandom_range(0, 3))
            0: imm = imm;
            1: imm = {{20{imm[11]}}, imm[11:0]};
            2: imm = {{19{imm[12]}}, imm[12:1], 1'b0};
            default: imm = imm & 32'hFFFF_F01F;
        endcase
        setReq(4'($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 1'($urandom), imm, 1'($urandom_range(0, 3) != 0));
    endtask

    // Advance one clock edge and update the model with the handshakes it implies.
    task automatic step(output bit pushed);
        bit  doPush, doPop;
        expT e;
        doPush = !rst && req_valid && (expQ.size() < int'(DEPTH));
        doPop  = !rst && out_ready && (expQ.size() != 0);
        e      = modelEnc(req_class, req_rd, req_rs1, req_rs2, req_funct3, req_alt, req_imm);
        @(posedge clk);
        pushed = doPush;
        if (rst) begin
            expQ.delete();
            mAddr = ADDRW'(BASE_ADDR);
        end else begin
            if (doPop) void'(expQ.pop_front());
            if (doPush) begin
                e.addr = mAddr;
                expQ.push_back(e);
                mAddr = mAddr + ADDRW'(1);
            end
        end
    endtask

    task automatic test_reset();
        bit p;
        @(negedge clk);
        rst = 1'b1;
        randReq();
        req_valid = 1'b1;
        out_ready = 1'b0;
        step(p);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        nChecks++; if (out_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        nChecks++; if (out_ins !== 32'h0) begin nFail++; $display("FAIL reset_ins: got %h expected 0", out_ins); end
        nChecks++; if (out_err !== 1'b0) begin nFail++; $display("FAIL reset_err: got %b expected 0", out_err); end
        nChecks++; if (out_addr !== ADDRW'(BASE_ADDR)) begin nFail++; $display("FAIL reset_addr: got %h expected %h", out_addr, ADDRW'(BASE_ADDR)); end
        nChecks++; if (req_ready !== 1'b1) begin nFail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        step(p);
    endtask

    localparam int NV = 10;
    logic [3:0]  vCls [NV] = '{4'd0, 4'd1, 4'd6, 4'd4, 4'd8, 4'd0, 4'd2, 4'd0, 4'd9, 4'd5};
    logic [4:0]  vRd  [NV] = '{5'd1, 5'd3, 5'd0, 5'd1, 5'd0, 5'd0, 5'd5, 5'd1, 5'd1, 5'd1};
    logic [4:0]  vRs1 [NV] = '{5'd2, 5'd1, 5'd1, 5'd0, 5'd2, 5'd0, 5'd0, 5'd1, 5'd1, 5'd2};
    logic [4:0]  vRs2 [NV] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0};
    logic [2:0]  vF3  [NV] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd5, 3'd1, 3'd3};
    logic        vAlt [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] vImm [NV] = '{32'd5, 32'd0, 32'hFFFF_FFFC, 32'd8, 32'd12, 32'd2048,
                              32'h1234_5000, 32'd3, 32'd123, 32'd4};
    logic [31:0] vIns [NV] = '{32'h0051_0093, 32'h4020_81B3, 32'hFE20_8EE3, 32'h0080_00EF,
                              32'h0051_2623, 32'h8000_0013, 32'h1234_52B7, 32'h4030_D093,
                              32'h0000_0013, 32'h0041_00E7};
    logic        vErr [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RANGE_CHECK, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic test_vectors();
        bit p;
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                nChecks++; if (out_valid !== 1'b1) begin nFail++; $display("FAIL vec%0d_valid: got %b expected 1", i - 1, out_valid); end
                nChecks++; if (out_ins !== vIns[i-1]) begin nFail++; $display("FAIL vec%0d_ins: got %h expected %h", i - 1, out_ins, vIns[i-1]); end
                nChecks++; if (out_err !== vErr[i-1]) begin nFail++; $display("FAIL vec%0d_err: got %b expected %b", i - 1, out_err, vErr[i-1]); end
                nChecks++; if (out_addr !== ADDRW'(BASE_ADDR + i - 1)) begin nFail++; $display("FAIL vec%0d_addr: got %h expected %h", i - 1, out_addr, ADDRW'(BASE_ADDR + i - 1)); end
            end
            if (i < NV) setReq(vCls[i], vRd[i], vRs1[i], vRs2[i], vF3[i], vAlt[i], vImm[i], 1'b1);
            else req_valid = 1'b0;
            out_ready = 1'b1;
            step(p);
        end
    endtask

    task automatic test_back_to_back();
        bit p;
        int sent = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) begin
                nChecks++; if (req_ready !== 1'b0) begin nFail++; $display("FAIL b2b_full_ready: got %b expected 0", req_ready); end
            end
            if (c == 3 || c == 4) begin
                nChecks++; if (out_ins !== vIns[0]) begin nFail++; $display("FAIL b2b_hold_ins: got %h expected %h", out_ins, vIns[0]); end
            end
            nChecks++; if (req_ready !== (expQ.size() < int'(DEPTH))) begin nFail++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, req_ready, expQ.size() < int'(DEPTH)); end
            nChecks++; if (out_valid !== (expQ.size() != 0)) begin nFail++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, out_valid, expQ.size() != 0); end
            if (expQ.size() != 0) begin
                nChecks++; if (out_ins !== expQ[0].ins || out_addr !== expQ[0].addr) begin nFail++; $display("FAIL b2b_head c%0d: got %h@%h expected %h@%h", c, out_ins, out_addr, expQ[0].ins, expQ[0].addr); end
            end
            if (sent < 3) setReq(vCls[sent], vRd[sent], vRs1[sent], vRs2[sent], vF3[sent], vAlt[sent], vImm[sent], 1'b1);
            else req_valid = 1'b0;
            out_ready = (c >= 5);
            step(p);
            if (p) sent++;
        end
    endtask

    task automatic test_reset_midburst();
        bit p;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            setReq(vCls[c], vRd[c], vRs1[c], vRs2[c], vF3[c], vAlt[c], vImm[c], 1'b1);
            out_ready = 1'b0;
            step(p);
        end
        @(negedge clk);
        nChecks++; if (out_valid !== 1'b1 || req_ready !== 1'b0) begin nFail++; $display("FAIL mid_prefill: got valid %b ready %b expected 1 0", out_valid, req_ready); end
        test_reset();
    endtask

    task automatic test_random();
        bit p;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            nChecks++; if (req_ready !== (expQ.size() < int'(DEPTH))) begin nFail++; $display("FAIL rand_ready c%0d: got %b expected %b", c, req_ready, expQ.size() < int'(DEPTH)); end
            nChecks++; if (out_valid !== (expQ.size() != 0)) begin nFail++; $display("FAIL rand_valid c%0d: got %b expected %b", c, out_valid, expQ.size() != 0); end
            if (expQ.size() != 0) begin
                nChecks++; if (out_ins !== expQ[0].ins) begin nFail++; $display("FAIL rand_ins c%0d: got %h expected %h", c, out_ins, expQ[0].ins); end
                nChecks++; if (out_addr !== expQ[0].addr) begin nFail++; $display("FAIL rand_addr c%0d: got %h expected %h", c, out_addr, expQ[0].addr); end
                nChecks++; if (out_err !== expQ[0].err) begin nFail++; $display("FAIL rand_err c%0d: got %b expected %b", c, out_err, expQ[0].err); end
            end
            randReq();
            out_ready = ($urandom_range(0, 3) != 0);
            rst = (c > 1200) && ($urandom_range(0, 299) == 0);
            step(p);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        mAddr = ADDRW'(BASE_ADDR);
        setReq(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
